// File: rtl/exu2lsu_pkg.sv
// exu2lsu_pkg
//   Shared definitions for the EXU -> LSU pipeline stage and its skid buffer:
//   field widths, reset codes, the stage state enum, the payload struct and
//   the payload reset / flush-clear constants.
package exu2lsu_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ARGS_WIDTH = 8;

   localparam logic [ADDR_WIDTH-1:0] ADDR_INIT    = '0;
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO    = '0;
   localparam logic [ARGS_WIDTH-1:0] INST_NAME_X  = '1;
   localparam logic [ARGS_WIDTH-1:0] RAM_BYT_X    = '1;
   localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_X = '1;

   // Occupancy of a two-entry stage register.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [ARGS_WIDTH-1:0] inst_name;
      logic                  ram_wr_en;
      logic [ARGS_WIDTH-1:0] ram_byt;
      logic                  reg_wr_en;
      logic [ARGS_WIDTH-1:0] reg_wr_src;
      logic [DATA_WIDTH-1:0] res_data;
      logic [DATA_WIDTH-1:0] rs2_data;
      logic [DATA_WIDTH-1:0] jmp_or_reg_data;
   } exu2lsu_pld_t;

   localparam exu2lsu_pld_t EXU2LSU_PLD_RST = '{
      pc:              ADDR_INIT,
      inst_name:       INST_NAME_X,
      ram_wr_en:       1'b0,
      ram_byt:         RAM_BYT_X,
      reg_wr_en:       1'b0,
      reg_wr_src:      REG_WR_SRC_X,
      res_data:        DATA_ZERO,
      rs2_data:        DATA_ZERO,
      jmp_or_reg_data: DATA_ZERO
   };

   // Bits cleared on flush: only the side-effecting enables. The rest of
   // the payload is left untouched since it is don't-care once invalid.
   localparam exu2lsu_pld_t EXU2LSU_PLD_FLUSH_CLR = '{
      pc:              '0,
      inst_name:       '0,
      ram_wr_en:       1'b1,
      ram_byt:         '0,
      reg_wr_en:       1'b1,
      reg_wr_src:      '0,
      res_data:        '0,
      rs2_data:        '0,
      jmp_or_reg_data: '0
   };

endpackage

// File: rtl/exu2lsu_stage_skid_buf.sv
// stage_skid_buf
//   Generic two-entry skid buffer used as a pipeline stage register.
//   The main register drives the outputs; the skid register catches one
//   extra entry when the consumer stalls, so in_ready_o depends only on
//   registered state.
//
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both high; valid never depends on ready, and a held output stays
//   bit-exact until it is taken. On this input side a transfer is also
//   suppressed while flush_i is high.
//
//   Ports:
//     clk_i, rst_i     clock, synchronous active-high reset
//     flush_i          squash held entries and the current input
//     in_valid_i/in_ready_o/in_data_i     upstream side
//     out_valid_o/out_ready_i/out_data_o  downstream side
//     state_o          current occupancy (debug)
module stage_skid_buf
   import exu2lsu_pkg::*;
#(
   parameter int unsigned    W            = 8,
   parameter logic [W-1:0]   RST_VAL      = '0,
   parameter logic [W-1:0]   CLR_ON_FLUSH = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o,
   output stage_state_e state_o
);

   stage_state_e state_q;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         in_fire;
   logic         out_fire;

   assign in_ready_o  = (state_q != ST_FULL);
   assign out_valid_o = (state_q != ST_EMPTY);
   assign out_data_o  = main_q;
   assign state_o     = state_q;

   assign in_fire  = in_valid_i && in_ready_o && !flush_i;
   assign out_fire = out_valid_o && out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
      end else if (flush_i) begin
         // A head entry consumed in this same cycle has already been seen
         // downstream; only the control enables need to be neutralised.
         state_q <= ST_EMPTY;
         main_q  <= main_q & ~CLR_ON_FLUSH;
         skid_q  <= skid_q & ~CLR_ON_FLUSH;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_q  <= in_data_i;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (in_fire && out_fire) begin
                  main_q <= in_data_i;
               end else if (in_fire) begin
                  skid_q  <= in_data_i;
                  state_q <= ST_FULL;
               end else if (out_fire) begin
                  state_q <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_q  <= skid_q;
                  state_q <= ST_BUSY;
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/exu2lsu.sv
// exu2lsu
//   Pipeline register between the execute unit and the load/store unit.
//   Packs the EXU result and the IDU control fields still needed downstream
//   into one payload, holds it in a two-entry skid buffer, and unpacks it
//   for the LSU one cycle later.
//
//   Ports:
//     i_sys_clk, i_sys_rst   clock, synchronous active-high reset
//     i_sys_flush            squash held entries and current input
//     i_pre_valid/o_pre_ready    EXU side handshake
//     o_post_valid/i_post_ready  LSU side handshake
//     i_*/o_* payload        pc, control codes/enables, result, store data,
//                            link/register data
//     o_dbg_state            stage occupancy (debug)
module exu2lsu
   import exu2lsu_pkg::*;
(
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   input  logic                  i_sys_flush,
   input  logic                  i_pre_valid,
   output logic                  o_pre_ready,
   output logic                  o_post_valid,
   input  logic                  i_post_ready,
   input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
   input  logic [ARGS_WIDTH-1:0] i_idu_ctr_inst_name,
   input  logic                  i_idu_ctr_ram_wr_en,
   input  logic [ARGS_WIDTH-1:0] i_idu_ctr_ram_byt,
   input  logic                  i_idu_ctr_reg_wr_en,
   input  logic [ARGS_WIDTH-1:0] i_idu_ctr_reg_wr_src,
   input  logic [DATA_WIDTH-1:0] i_exu_res_data,
   input  logic [DATA_WIDTH-1:0] i_idu_rs2_data,
   input  logic [DATA_WIDTH-1:0] i_idu_jmp_or_reg_data,
   output logic [ADDR_WIDTH-1:0] o_ifu_pc,
   output logic [ARGS_WIDTH-1:0] o_idu_ctr_inst_name,
   output logic                  o_idu_ctr_ram_wr_en,
   output logic [ARGS_WIDTH-1:0] o_idu_ctr_ram_byt,
   output logic                  o_idu_ctr_reg_wr_en,
   output logic [ARGS_WIDTH-1:0] o_idu_ctr_reg_wr_src,
   output logic [DATA_WIDTH-1:0] o_exu_res_data,
   output logic [DATA_WIDTH-1:0] o_idu_rs2_data,
   output logic [DATA_WIDTH-1:0] o_idu_jmp_or_reg_data,
   output stage_state_e          o_dbg_state
);

   exu2lsu_pld_t pld_in;
   exu2lsu_pld_t pld_out;

   assign pld_in = '{
      pc:              i_ifu_pc,
      inst_name:       i_idu_ctr_inst_name,
      ram_wr_en:       i_idu_ctr_ram_wr_en,
      ram_byt:         i_idu_ctr_ram_byt,
      reg_wr_en:       i_idu_ctr_reg_wr_en,
      reg_wr_src:      i_idu_ctr_reg_wr_src,
      res_data:        i_exu_res_data,
      rs2_data:        i_idu_rs2_data,
      jmp_or_reg_data: i_idu_jmp_or_reg_data
   };

   stage_skid_buf #(
      .W            ($bits(exu2lsu_pld_t)),
      .RST_VAL      (EXU2LSU_PLD_RST),
      .CLR_ON_FLUSH (EXU2LSU_PLD_FLUSH_CLR)
   ) u_skid (
      .clk_i       (i_sys_clk),
      .rst_i       (i_sys_rst),
      .flush_i     (i_sys_flush),
      .in_valid_i  (i_pre_valid),
      .in_ready_o  (o_pre_ready),
      .in_data_i   (pld_in),
      .out_valid_o (o_post_valid),
      .out_ready_i (i_post_ready),
      .out_data_o  (pld_out),
      .state_o     (o_dbg_state)
   );

   assign o_ifu_pc              = pld_out.pc;
   assign o_idu_ctr_inst_name   = pld_out.inst_name;
   assign o_idu_ctr_ram_wr_en   = pld_out.ram_wr_en;
   assign o_idu_ctr_ram_byt     = pld_out.ram_byt;
   assign o_idu_ctr_reg_wr_en   = pld_out.reg_wr_en;
   assign o_idu_ctr_reg_wr_src  = pld_out.reg_wr_src;
   assign o_exu_res_data        = pld_out.res_data;
   assign o_idu_rs2_data        = pld_out.rs2_data;
   assign o_idu_jmp_or_reg_data = pld_out.jmp_or_reg_data;

endmodule

// File: tb/tb_exu2lsu.sv
// tb_exu2lsu
//   Directed bench for exu2lsu: a queue model of the stage is compared on
//   every falling edge, and literal expectations pin reset values, ordering
//   and flush behaviour.
module tb_exu2lsu;
   import exu2lsu_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [7:0]  inst_name;
      logic        ram_wr_en;
      logic [7:0]  ram_byt;
      logic        reg_wr_en;
      logic [7:0]  reg_wr_src;
      logic [31:0] res_data;
      logic [31:0] rs2_data;
      logic [31:0] jmp_or_reg_data;
   } tb_pld_t;

   localparam tb_pld_t RST_LIT = '{
      pc: 32'h0, inst_name: 8'hFF, ram_wr_en: 1'b0, ram_byt: 8'hFF,
      reg_wr_en: 1'b0, reg_wr_src: 8'hFF, res_data: 32'h0,
      rs2_data: 32'h0, jmp_or_reg_data: 32'h0
   };

   // ---------------- clock / reset / signals ----------------
   logic         clk = 1'b0;
   logic         rst, flush, pre_valid, pre_ready, post_valid, post_ready;
   logic [31:0]  i_pc, i_res, i_rs2, i_jmp;
   logic [7:0]   i_name, i_byt, i_src;
   logic         i_ram_wr, i_reg_wr;
   logic [31:0]  o_pc, o_res, o_rs2, o_jmp;
   logic [7:0]   o_name, o_byt, o_src;
   logic         o_ram_wr, o_reg_wr;
   stage_state_e dbg_state;

   always #5 clk = ~clk;

   exu2lsu dut (
      .i_sys_clk             (clk),
      .i_sys_rst             (rst),
      .i_sys_flush           (flush),
      .i_pre_valid           (pre_valid),
      .o_pre_ready           (pre_ready),
      .o_post_valid          (post_valid),
      .i_post_ready          (post_ready),
      .i_ifu_pc              (i_pc),
      .i_idu_ctr_inst_name   (i_name),
      .i_idu_ctr_ram_wr_en   (i_ram_wr),
      .i_idu_ctr_ram_byt     (i_byt),
      .i_idu_ctr_reg_wr_en   (i_reg_wr),
      .i_idu_ctr_reg_wr_src  (i_src),
      .i_exu_res_data        (i_res),
      .i_idu_rs2_data        (i_rs2),
      .i_idu_jmp_or_reg_data (i_jmp),
      .o_ifu_pc              (o_pc),
      .o_idu_ctr_inst_name   (o_name),
      .o_idu_ctr_ram_wr_en   (o_ram_wr),
      .o_idu_ctr_ram_byt     (o_byt),
      .o_idu_ctr_reg_wr_en   (o_reg_wr),
      .o_idu_ctr_reg_wr_src  (o_src),
      .o_exu_res_data        (o_res),
      .o_idu_rs2_data        (o_rs2),
      .o_idu_jmp_or_reg_data (o_jmp),
      .o_dbg_state           (dbg_state)
   );

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
   endtask

   // ---------------- model: FIFO of at most two entries ----------------
   tb_pld_t     mq[$];
   tb_pld_t     shown = RST_LIT;
   logic [31:0] fired_q[$];

   function automatic tb_pld_t cur_in();
      tb_pld_t p;
      p = '{pc: i_pc, inst_name: i_name, ram_wr_en: i_ram_wr, ram_byt: i_byt,
            reg_wr_en: i_reg_wr, reg_wr_src: i_src, res_data: i_res,
            rs2_data: i_rs2, jmp_or_reg_data: i_jmp};
      return p;
   endfunction

   always @(posedge clk) begin
      bit in_fire, out_fire;
      if (rst) begin
         mq.delete();
         shown = RST_LIT;
      end else begin
         out_fire = (mq.size() > 0) && post_ready;
         in_fire  = pre_valid && (mq.size() < 2) && !flush;
         if (out_fire) fired_q.push_back(mq[0].pc);
         if (flush) begin
            mq.delete();
            shown.ram_wr_en = 1'b0;
            shown.reg_wr_en = 1'b0;
         end else begin
            if (out_fire) void'(mq.pop_front());
            if (in_fire) mq.push_back(cur_in());
            if (mq.size() > 0) shown = mq[0];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (check_en) begin
         stage_state_e exp_st;
         exp_st = (mq.size() == 0) ? ST_EMPTY : (mq.size() == 1) ? ST_BUSY : ST_FULL;
         chk("post_valid", 256'(post_valid), 256'(mq.size() != 0));
         chk("pre_ready", 256'(pre_ready), 256'(mq.size() < 2));
         chk("state", 256'(dbg_state), 256'(exp_st));
         chk("payload",
             256'({o_pc, o_name, o_ram_wr, o_byt, o_reg_wr, o_src, o_res, o_rs2, o_jmp}),
             256'(shown));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] pc, input logic rw, input logic gw);
      pre_valid = v;
      i_pc      = pc;
      i_name    = pc[7:0] ^ 8'h5A;
      i_ram_wr  = rw;
      i_byt     = pc[9:2];
      i_reg_wr  = gw;
      i_src     = pc[7:0] + 8'd1;
      i_res     = pc ^ 32'hDEAD_0000;
      i_rs2     = ~pc;
      i_jmp     = pc + 32'd4;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 256'(post_valid), 256'(1'b0));
      chk({tag, "_ready"}, 256'(pre_ready), 256'(1'b1));
      chk({tag, "_pc"}, 256'(o_pc), 256'(32'h0));
      chk({tag, "_name"}, 256'(o_name), 256'(8'hFF));
      chk({tag, "_byt"}, 256'(o_byt), 256'(8'hFF));
      chk({tag, "_src"}, 256'(o_src), 256'(8'hFF));
      chk({tag, "_wen"}, 256'({o_ram_wr, o_reg_wr}), 256'(2'b00));
      chk({tag, "_data"}, 256'({o_res, o_rs2, o_jmp}), 256'(96'h0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [11:0] pv_pat;
      logic [11:0] pr_pat;
      rst = 1'b1; flush = 1'b0; post_ready = 1'b0;
      set_in(1'b1, 32'h8000_0000, 1'b1, 1'b1);

      // Reset held two cycles with a valid input present.
      step();
      check_en = 1'b1;
      chk_reset_vals("rst1");
      step();
      chk_reset_vals("rst2");

      // Streaming.
      rst = 1'b0; post_ready = 1'b1;
      set_in(1'b1, 32'h8000_0000, 1'b0, 1'b1);
      step();
      chk("stream0_pc", 256'(o_pc), 256'(32'h8000_0000));
      chk("stream0_res", 256'(o_res), 256'(32'h5EAD_0000));
      set_in(1'b1, 32'h8000_0004, 1'b0, 1'b1);
      step();
      chk("stream1_pc", 256'(o_pc), 256'(32'h8000_0004));
      chk("stream1_ready", 256'(pre_ready), 256'(1'b1));

      // Stall three cycles; 0x08 goes to skid, 0x0C must not be accepted.
      post_ready = 1'b0;
      set_in(1'b1, 32'h8000_0008, 1'b0, 1'b1);
      step();
      chk("stall_ready", 256'(pre_ready), 256'(1'b0));
      chk("stall_pc", 256'(o_pc), 256'(32'h8000_0004));
      set_in(1'b1, 32'h8000_000C, 1'b0, 1'b1);
      step();
      step();
      chk("stall_hold_pc", 256'(o_pc), 256'(32'h8000_0004));
      chk("stall_hold_rs2", 256'(o_rs2), 256'(32'h7FFF_FFFB));
      post_ready = 1'b1;
      set_in(1'b0, 32'h8000_000C, 1'b0, 1'b0);
      step();
      chk("drain_pc", 256'(o_pc), 256'(32'h8000_0008));
      chk("drain_ready", 256'(pre_ready), 256'(1'b1));
      step();
      chk("drain_empty", 256'(post_valid), 256'(1'b0));

      // Flush while full.
      post_ready = 1'b0;
      set_in(1'b1, 32'h8000_0010, 1'b0, 1'b1);
      step();
      set_in(1'b1, 32'h8000_0014, 1'b0, 1'b1);
      step();
      chk("full_ready", 256'(pre_ready), 256'(1'b0));
      flush = 1'b1;
      set_in(1'b1, 32'h8000_000C, 1'b0, 1'b1);
      step();
      chk("flush_valid", 256'(post_valid), 256'(1'b0));
      chk("flush_ready", 256'(pre_ready), 256'(1'b1));
      chk("flush_regwr", 256'(o_reg_wr), 256'(1'b0));
      flush = 1'b0;
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      chk("flush_after", 256'(post_valid), 256'(1'b0));

      // Flush coincident with output fire of a store.
      set_in(1'b1, 32'h8000_0018, 1'b1, 1'b0);
      step();
      chk("store_valid", 256'(post_valid), 256'(1'b1));
      chk("store_wr", 256'(o_ram_wr), 256'(1'b1));
      flush = 1'b1; post_ready = 1'b1;
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      chk("ff_valid", 256'(post_valid), 256'(1'b0));
      chk("ff_wr", 256'(o_ram_wr), 256'(1'b0));
      flush = 1'b0;
      chk("fired_count", 256'(fired_q.size()), 256'(4));
      if (fired_q.size() == 4)
         chk("fired_order", 256'({fired_q[0], fired_q[1], fired_q[2], fired_q[3]}),
             256'({32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0018}));

      // Reset mid-stall.
      post_ready = 1'b0;
      set_in(1'b1, 32'h8000_0020, 1'b1, 1'b1);
      step();
      set_in(1'b1, 32'h8000_0024, 1'b1, 1'b1);
      step();
      chk("pre_rst_ready", 256'(pre_ready), 256'(1'b0));
      rst = 1'b1;
      set_in(1'b1, 32'h8000_0028, 1'b1, 1'b1);
      step();
      chk_reset_vals("midrst");
      rst = 1'b0;
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      chk("post_rst_valid", 256'(post_valid), 256'(1'b0));

      // Mixed valid/ready pattern, checked by the per-cycle model compare.
      pv_pat = 12'b1110_1111_0111;
      pr_pat = 12'b1010_0110_1101;
      for (int i = 0; i < 12; i++) begin
         post_ready = pr_pat[i];
         set_in(pv_pat[i], 32'h8000_0100 + 32'(4 * i), 1'(i), 1'(i >> 1));
         step();
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0);
      post_ready = 1'b1;
      repeat (3) step();
      chk("final_empty", 256'(post_valid), 256'(1'b0));

      @(negedge clk);
      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
